// File: rtl/serial_eq_ctrl_amisha_pkg.sv
// Shared types and defaults for the bit-serial equality controller.
package eq_ctrl_pkg_amisha;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_EARLY_EXIT = 1;

  // Bit-index width for a given operand width, never narrower than one bit.
  function automatic int idx_width_f(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_eq_ctrl_amisha_eq1.sv
// Single-bit equality cell shared by every step of the serial compare.
module eq1_cell_amisha (
  input  logic i_a,
  input  logic i_b,
  output logic o_eq
);

  assign o_eq = ~(i_a ^ i_b);

endmodule

// File: rtl/serial_eq_ctrl_amisha.sv
// Bit-serial equality controller: captures two operands, walks them LSB first
// through one 1-bit equality cell, and reports equality plus the first
// mismatching bit index with a one-cycle done pulse.
module serial_eq_ctrl_amisha
  import eq_ctrl_pkg_amisha::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int EARLY_EXIT = DEFAULT_EARLY_EXIT,
  parameter int IDX_W      = idx_width_f(WIDTH)
) (
  input  logic             clk_amisha,
  input  logic             rst_n_amisha,
  input  logic             start_amisha,
  input  logic [WIDTH-1:0] a_amisha,
  input  logic [WIDTH-1:0] b_amisha,
  output logic             busy_amisha,
  output logic             done_amisha,
  output logic             eq_amisha,
  output logic [IDX_W-1:0] mis_idx_amisha
);

  state_e             r_state;
  state_e             w_stateNext;
  logic [WIDTH-1:0]   r_shA;
  logic [WIDTH-1:0]   r_shB;
  logic [IDX_W-1:0]   r_idx;
  logic               r_acc;
  logic               r_eq;
  logic [IDX_W-1:0]   r_misIdx;
  logic               r_misSeen;
  logic               w_bitEq;
  logic               w_lastBit;

  // The operands shift right every compare step, so the cell always sees bit 0.
  eq1_cell_amisha u_eq1 (
    .i_a  (r_shA[0]),
    .i_b  (r_shB[0]),
    .o_eq (w_bitEq)
  );

  assign w_lastBit = (r_idx == IDX_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: a compare ends on the MSB or, if enabled, on the first mismatch.
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE: begin
        if (start_amisha) begin
          w_stateNext = CMP;
        end
      end
      CMP: begin
        if (((EARLY_EXIT != 0) && !w_bitEq) || w_lastBit) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, shifting, accumulation and first-mismatch capture.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      r_shA     <= '0;
      r_shB     <= '0;
      r_idx     <= '0;
      r_acc     <= 1'b0;
      r_eq      <= 1'b0;
      r_misIdx  <= '0;
      r_misSeen <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_amisha) begin
            r_shA     <= a_amisha;
            r_shB     <= b_amisha;
            r_idx     <= '0;
            r_acc     <= 1'b1;
            r_eq      <= 1'b0;
            r_misIdx  <= '0;
            r_misSeen <= 1'b0;
          end
        end
        CMP: begin
          r_acc <= r_acc & w_bitEq;
          r_shA <= r_shA >> 1;
          r_shB <= r_shB >> 1;
          if (!w_bitEq && !r_misSeen) begin
            r_misIdx  <= r_idx;
            r_misSeen <= 1'b1;
          end
          if (w_stateNext == DONE) begin
            r_eq <= r_acc & w_bitEq;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_amisha    = (r_state != IDLE);
  assign done_amisha    = (r_state == DONE);
  assign eq_amisha      = r_eq;
  assign mis_idx_amisha = r_misIdx;

endmodule

// File: doc/serial_eq_ctrl_amisha.md
# serial_eq_ctrl_amisha

Sequential controller that compares two WIDTH-bit operands one bit per cycle, LSB first, through a single 1-bit equality cell. It accepts a start request, captures both operands, and steps the bit index. It stops either on the first mismatch (optional) or after the MSB, then reports equality and the first mismatching bit index with a one-cycle done pulse. It sits between a requesting datapath and the shared 1-bit comparator, trading area for WIDTH cycles of latency.

## Interface
Parameters:
- WIDTH, 8, operand width; legal range 2..256.
- EARLY_EXIT, 1, 1 = stop at first mismatch; 0 = always compare all WIDTH bits.
- IDX_W, $clog2(WIDTH), width of the bit index; derived, do not override.

Ports:
- clk_amisha, in, 1, single clock, rising edge.
- rst_n_amisha, in, 1, reset; asynchronous, active-low.
- start_amisha, in, 1, request; sampled only in IDLE.
- a_amisha, in, WIDTH, operand A; captured on the accepting edge.
- b_amisha, in, WIDTH, operand B; captured on the accepting edge.
- busy_amisha, out, 1, high in CMP and DONE.
- done_amisha, out, 1, one-cycle pulse, high in DONE.
- eq_amisha, out, 1, result; 1 = all compared bits equal.
- mis_idx_amisha, out, IDX_W, index of the first mismatching bit.

## Operation
- States:
  - IDLE: waits for start.
  - CMP: steps through bits.
  - DONE: asserts the done pulse for one cycle, then returns to IDLE.
- IDLE -> CMP, when start_amisha=1 at the edge:
  - load a_amisha/b_amisha into shift registers;
  - idx <= 0;
  - accumulator <= 1.
- CMP, each edge, using bit idx of the captured operands:
  - acc <= acc & eq1(a[idx], b[idx]).
  - First mismatch: record mis_idx <= idx. Later mismatches never overwrite it.
  - With EARLY_EXIT=1, a mismatch goes to DONE immediately.
  - Otherwise idx==WIDTH-1 goes to DONE; else idx <= idx+1.
- DONE:
  - done_amisha=1 and eq_amisha=acc are visible;
  - at the next edge, go to IDLE.
- Result hold: eq_amisha and mis_idx_amisha hold their last values until the next accepted start. At that accepting edge they clear to eq=0 and mis_idx=0.
- Clean compare: when eq_amisha=1, mis_idx_amisha=0.
- start_amisha while busy is ignored; there is no queueing.
- Operand changes after the accepting edge have no effect.
- Idx bounds: idx never exceeds WIDTH-1 and never wraps.

## Timing
- Reset (rst_n_amisha low, any time, asynchronous):
  - state = IDLE;
  - busy_amisha, done_amisha, eq_amisha = 0;
  - mis_idx_amisha = 0;
  - shift registers and idx = 0.
- Reset mid-operation aborts with no done pulse. Release is synchronous to the next rising edge.
- Edge 0 accepts start. Edge j (1..WIDTH) evaluates bit j-1.
- Full compare: done high in the cycle after edge WIDTH, deasserted after edge WIDTH+1. Total latency WIDTH+1 cycles from the start edge to the end of the done cycle.
- Early exit at bit i: done high in the cycle after edge i+1.
- Back-to-back: start held high through DONE is accepted at the first edge in IDLE. The minimum period is WIDTH+2 cycles for a full compare.
- busy_amisha rises the cycle after the accepting edge and falls with done_amisha.

## Structure
- Package eq_ctrl_pkg_amisha holds:
  - the state enum {IDLE, CMP, DONE}, 2-bit encoding;
  - localparam defaults for WIDTH and EARLY_EXIT;
  - an idx-width helper function.
- Sub-module eq1_cell_amisha: 1-bit combinational XNOR equality cell, instantiated once and fed by the shift-register LSBs.
- Operands are shifted right each CMP cycle, so the cell always sees bit 0.

## Test plan
- WIDTH=8, EARLY_EXIT=1:
  - a=8'hA5, b=8'hA5 -> done after edge 8; eq=1; mis_idx=0.
  - a=8'hA5, b=8'hA4 -> mismatch at bit 0; done after edge 1; eq=0; mis_idx=0.
- WIDTH=8, EARLY_EXIT=0: a=8'h0F, b=8'h8B -> done after edge 8; eq=0; mis_idx=2, not 7.
- Start pulsed again during CMP with different operands -> ignored; result reflects the first operands only.
- Reset asserted at edge 3 of a compare -> outputs zero immediately; no done pulse. A new start after release completes normally.
- start held high continuously, alternating equal and unequal operands -> each done pulse is exactly one cycle, WIDTH+2 cycles apart for equal operands; eq toggles to match.
